// File: rtl/dyna_status_rx.sv
`timescale 1ns/1ps
// Dynamixel status-packet receiver: 8N1 UART deserialiser feeding a packet decoder
// that reports good packets, checksum failures and framing/timeout aborts.
module dyna_status_rx #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 1_000_000,
    parameter int unsigned MAX_PARAMS  = 4,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_en,
    input  logic                    rx,
    output logic                    pkt_valid,
    output logic [7:0]              pkt_id,
    output logic [7:0]              pkt_err,
    output logic [8*MAX_PARAMS-1:0] pkt_params,
    output logic [3:0]              pkt_nparams,
    output logic                    chk_fail,
    output logic                    frame_err
);

    localparam int unsigned CPB   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PW    = 8 * MAX_PARAMS;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [2:0] {P_H1, P_H2, P_ID, P_LEN, P_ERR, P_PAR, P_CHK} pstate_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    bstate_t          bstate_q;
    logic [CNT_W-1:0] bcnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             byte_stb_q;
    logic             stop_err_q;

    pstate_t          pstate_q;
    logic [7:0]       id_q, err_q, sum_q;
    logic [3:0]       nparams_q, pidx_q;
    logic [PW-1:0]    par_q;
    logic [TMO_W-1:0] tmo_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Byte deserialiser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bstate_q   <= B_IDLE;
            bcnt_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_stb_q <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            byte_stb_q <= 1'b0;
            stop_err_q <= 1'b0;
            if (!rx_en) begin
                bstate_q <= B_IDLE;
                bcnt_q   <= '0;
                bit_q    <= '0;
            end else begin
                case (bstate_q)
                    B_IDLE: begin
                        bcnt_q <= '0;
                        bit_q  <= '0;
                        if (rx_prev_q && !rx_sync_q) bstate_q <= B_START;
                    end
                    B_START: begin
                        if (bcnt_q == CNT_W'(HALF - 1)) begin
                            bcnt_q   <= '0;
                            bstate_q <= rx_sync_q ? B_IDLE : B_DATA;
                        end else begin
                            bcnt_q <= bcnt_q + CNT_W'(1);
                        end
                    end
                    B_DATA: begin
                        if (bcnt_q == CNT_W'(CPB - 1)) begin
                            bcnt_q  <= '0;
                            shift_q <= {rx_sync_q, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) bstate_q <= B_STOP;
                        end else begin
                            bcnt_q <= bcnt_q + CNT_W'(1);
                        end
                    end
                    B_STOP: begin
                        if (bcnt_q == CNT_W'(CPB - 1)) begin
                            bcnt_q     <= '0;
                            bstate_q   <= B_IDLE;
                            byte_stb_q <= rx_sync_q;
                            stop_err_q <= !rx_sync_q;
                        end else begin
                            bcnt_q <= bcnt_q + CNT_W'(1);
                        end
                    end
                    default: bstate_q <= B_IDLE;
                endcase
            end
        end
    end

    // Packet decoder with checksum, inter-byte timeout and registered result fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pstate_q    <= P_H1;
            id_q        <= '0;
            err_q       <= '0;
            sum_q       <= '0;
            nparams_q   <= '0;
            pidx_q      <= '0;
            par_q       <= '0;
            tmo_q       <= '0;
            pkt_valid   <= 1'b0;
            pkt_id      <= '0;
            pkt_err     <= '0;
            pkt_params  <= '0;
            pkt_nparams <= '0;
            chk_fail    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            chk_fail  <= 1'b0;
            frame_err <= 1'b0;
            if (!rx_en) begin
                pstate_q <= P_H1;
                tmo_q    <= '0;
            end else if (stop_err_q) begin
                frame_err <= 1'b1;
                pstate_q  <= P_H1;
                tmo_q     <= '0;
            end else if (byte_stb_q) begin
                tmo_q <= '0;
                case (pstate_q)
                    P_H1: if (shift_q == 8'hFF) pstate_q <= P_H2;
                    P_H2: pstate_q <= (shift_q == 8'hFF) ? P_ID : P_H1;
                    P_ID: begin
                        if (shift_q != 8'hFF) begin
                            id_q     <= shift_q;
                            sum_q    <= shift_q;
                            pstate_q <= P_LEN;
                        end
                    end
                    P_LEN: begin
                        if (shift_q < 8'd2 || shift_q > 8'(MAX_PARAMS + 2)) begin
                            frame_err <= 1'b1;
                            pstate_q  <= P_H1;
                        end else begin
                            nparams_q <= 4'(shift_q - 8'd2);
                            sum_q     <= sum_q + shift_q;
                            pidx_q    <= '0;
                            par_q     <= '0;
                            pstate_q  <= P_ERR;
                        end
                    end
                    P_ERR: begin
                        err_q    <= shift_q;
                        sum_q    <= sum_q + shift_q;
                        pstate_q <= (nparams_q != 4'd0) ? P_PAR : P_CHK;
                    end
                    P_PAR: begin
                        for (int i = 0; i < int'(MAX_PARAMS); i++) begin
                            if (pidx_q == 4'(i)) par_q[i*8 +: 8] <= shift_q;
                        end
                        sum_q  <= sum_q + shift_q;
                        pidx_q <= pidx_q + 4'd1;
                        if (pidx_q + 4'd1 == nparams_q) pstate_q <= P_CHK;
                    end
                    P_CHK: begin
                        if (shift_q == ~sum_q) begin
                            pkt_valid   <= 1'b1;
                            pkt_id      <= id_q;
                            pkt_err     <= err_q;
                            pkt_params  <= par_q;
                            pkt_nparams <= nparams_q;
                        end else begin
                            chk_fail <= 1'b1;
                        end
                        pstate_q <= P_H1;
                    end
                    default: pstate_q <= P_H1;
                endcase
            end else if (pstate_q != P_H1) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    frame_err <= 1'b1;
                    pstate_q  <= P_H1;
                    tmo_q     <= '0;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dyna_status_rx.sv
`timescale 1ns/1ps
// Directed bench for dyna_status_rx: serialises status packets onto rx and
// checks decoded fields and pulse counts against hand-computed values.
module tb_dyna_status_rx;

    localparam int CPB = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_en = 1'b1;
    logic        rx = 1'b1;
    logic        pkt_valid;
    logic [7:0]  pkt_id;
    logic [7:0]  pkt_err;
    logic [31:0] pkt_params;
    logic [3:0]  pkt_nparams;
    logic        chk_fail;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_v = 0, n_c = 0, n_f = 0;
    int b_v = 0, b_c = 0, b_f = 0;
    logic [7:0] tx_q[$];

    dyna_status_rx #(
        .CLK_FREQ(50_000_000), .BAUD(1_000_000), .MAX_PARAMS(4), .TIMEOUT_CYC(5000)
    ) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .rx(rx),
        .pkt_valid(pkt_valid), .pkt_id(pkt_id), .pkt_err(pkt_err),
        .pkt_params(pkt_params), .pkt_nparams(pkt_nparams),
        .chk_fail(chk_fail), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid) n_v++;
        if (chk_fail)  n_c++;
        if (frame_err) n_f++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_v = n_v; b_c = n_c; b_f = n_f;
    endtask

    task automatic chk_pulses(input string tag, input int ev, input int ec, input int ef);
        chk({tag, ".valid"}, 64'(n_v - b_v), 64'(ev));
        chk({tag, ".chk_fail"}, 64'(n_c - b_c), 64'(ec));
        chk({tag, ".frame_err"}, 64'(n_f - b_f), 64'(ef));
    endtask

    task automatic chk_fields(input string tag, input logic [7:0] id, input logic [7:0] er,
                              input logic [31:0] par, input logic [3:0] np);
        chk({tag, ".id"}, 64'(pkt_id), 64'(id));
        chk({tag, ".err"}, 64'(pkt_err), 64'(er));
        chk({tag, ".params"}, 64'(pkt_params), 64'(par));
        chk({tag, ".nparams"}, 64'(pkt_nparams), 64'(np));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic send_ping();
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        send_q();
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("reset.valid", 64'(pkt_valid), 64'd0);
        chk("reset.chk_fail", 64'(chk_fail), 64'd0);
        chk("reset.frame_err", 64'(frame_err), 64'd0);
        chk_fields("reset", 8'h00, 8'h00, 32'h0, 4'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 1: ping reply
        snap();
        send_ping();
        chk_pulses("ping", 1, 0, 0);
        chk_fields("ping", 8'h01, 8'h00, 32'h0, 4'd0);

        // 2: position reply
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD8};
        send_q();
        chk_pulses("pos", 1, 0, 0);
        chk_fields("pos", 8'h01, 8'h00, 32'h0000_0220, 4'd2);

        // 3: bad checksum keeps previous fields
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD9};
        send_q();
        chk_pulses("badchk", 0, 1, 0);
        chk_fields("badchk", 8'h01, 8'h00, 32'h0000_0220, 4'd2);

        // 4: noise then FF FF FF resync
        snap();
        tx_q = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h04, 8'hF8};
        send_q();
        chk_pulses("resync", 1, 0, 0);
        chk_fields("resync", 8'h01, 8'h04, 32'h0, 4'd0);

        // 5a: LEN above MAX_PARAMS+2
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h07};
        send_q();
        chk_pulses("badlen", 0, 0, 1);
        snap();
        send_ping();
        chk_pulses("badlen.ping", 1, 0, 0);
        chk_fields("badlen.ping", 8'h01, 8'h00, 32'h0, 4'd0);

        // 5b: zero stop bit mid-packet
        snap();
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b0);
        repeat (CPB) @(negedge clk);
        chk_pulses("stop0", 0, 0, 1);
        snap();
        send_ping();
        chk_pulses("stop0.ping", 1, 0, 0);

        // 5c: stalled stream; no abort before the timeout, one abort after
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h01};
        send_q();
        repeat (4000) @(negedge clk);
        chk_pulses("stall.early", 0, 0, 0);
        repeat (2000) @(negedge clk);
        chk_pulses("stall", 0, 0, 1);
        snap();
        send_ping();
        chk_pulses("stall.ping", 1, 0, 0);

        // 6a: rx_en dropped mid-packet
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h01};
        send_q();
        rx_en = 1'b0;
        tx_q = '{8'h02, 8'h00, 8'hFC};
        send_q();
        rx_en = 1'b1;
        repeat (20) @(negedge clk);
        chk_pulses("rxen", 0, 0, 0);
        snap();
        send_ping();
        chk_pulses("rxen.ping", 1, 0, 0);

        // Full parameter load, then a short packet zeroes unused bytes
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h06, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h4E};
        send_q();
        chk_pulses("max", 1, 0, 0);
        chk_fields("max", 8'h01, 8'h00, 32'h4433_2211, 4'd4);
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h02, 8'h03, 8'h00, 8'h55, 8'hA5,
                 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        send_q();
        chk_pulses("b2b", 2, 0, 0);
        chk_fields("b2b", 8'h01, 8'h00, 32'h0, 4'd0);
        snap();
        tx_q = '{8'hFF, 8'hFF, 8'h02, 8'h03, 8'h80, 8'h55, 8'h25};
        send_q();
        chk_pulses("one", 1, 0, 0);
        chk_fields("one", 8'h02, 8'h80, 32'h0000_0055, 4'd1);

        // 6b: reset mid-byte
        tx_q = '{8'hFF, 8'hFF, 8'h01};
        send_q();
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        rx = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk_fields("rst", 8'h00, 8'h00, 32'h0, 4'd0);
        reset = 1'b0;
        repeat (CPB * 12) @(negedge clk);
        snap();
        send_ping();
        chk_pulses("rst.ping", 1, 0, 0);
        chk_fields("rst.ping", 8'h01, 8'h00, 32'h0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
